// File: rtl/cache_wb_buffer_if.sv
// Bus bundle between the cache, the write-back buffer and the AXI write bridge.
// The slave modport is the buffer's view; the master modport is the
// surrounding environment (cache push side plus bridge side).
interface cache_wb_buffer_if;
  // cache -> buffer push side
  logic         wb_valid;
  logic         wb_ready;
  logic         wb_uncache;
  logic [31:0]  wb_addr;
  logic [3:0]   wb_wstrb;
  logic [127:0] wb_data;
  // buffer -> bridge request side
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic         wr_rdy;
  logic         wr_done;
  // read-ordering and status
  logic [31:0]  rd_chk_addr;
  logic         conflict;
  logic         idle;
  logic         err;

  modport slave (
    input  wb_valid, wb_uncache, wb_addr, wb_wstrb, wb_data,
    input  wr_rdy, wr_done, rd_chk_addr,
    output wb_ready, wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
    output conflict, idle, err
  );

  modport master (
    output wb_valid, wb_uncache, wb_addr, wb_wstrb, wb_data,
    output wr_rdy, wr_done, rd_chk_addr,
    input  wb_ready, wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
    input  conflict, idle, err
  );
endinterface

// File: rtl/cache_wb_buffer.sv
// Write-back buffer: queues dirty victim lines and uncached stores, issues
// them in order to the AXI write bridge, counts unacknowledged writes and
// flags read-after-write hazards for the miss-read path.
module cache_wb_buffer #(
  parameter int DEPTH   = 2,
  parameter int MAX_OUT = 2
) (
  input  logic              clk,
  input  logic              reset,
  cache_wb_buffer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_OUT + 1);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]  out_cnt_q, out_cnt_d;

  // Entry storage. Kept in flops rather than block RAM because every entry
  // is compared against rd_chk_addr in the same cycle.
  logic           ent_uncache_q [DEPTH];
  logic [31:0]    ent_addr_q    [DEPTH];
  logic [3:0]     ent_wstrb_q   [DEPTH];
  logic [127:0]   ent_data_q    [DEPTH];

  logic           empty, full, push, fire, req;
  logic [AW-1:0]  head_idx, tail_idx;
  logic [AW:0]    count;
  logic [DEPTH-1:0] hit;

  assign head_idx = head_q[AW-1:0];
  assign tail_idx = tail_q[AW-1:0];
  assign count    = tail_q - head_q;
  assign empty    = (head_q == tail_q);
  assign full     = (head_q[AW] != tail_q[AW]) && (head_idx == tail_idx);
  assign req      = !empty && (out_cnt_q < CW'(MAX_OUT));
  assign push     = bus.wb_valid && !full;
  assign fire     = req && bus.wr_rdy;

  assign bus.wb_ready = !full;
  assign bus.wr_req   = req;

  // Request encoding from the head entry; all zeros while no request.
  always_comb begin
    bus.wr_type  = 3'b000;
    bus.wr_addr  = 32'h0;
    bus.wr_wstrb = 4'h0;
    bus.wr_data  = 128'h0;
    if (req) begin
      if (ent_uncache_q[head_idx]) begin
        bus.wr_type  = 3'b010;
        bus.wr_addr  = ent_addr_q[head_idx];
        bus.wr_wstrb = ent_wstrb_q[head_idx];
        bus.wr_data  = {96'h0, ent_data_q[head_idx][31:0]};
      end else begin
        bus.wr_type  = 3'b100;
        bus.wr_addr  = {ent_addr_q[head_idx][31:4], 4'h0};
        bus.wr_wstrb = 4'hF;
        bus.wr_data  = ent_data_q[head_idx];
      end
    end
  end

  // Per-slot hazard compare: slot is live if its distance from head is
  // below the occupancy; lines match on 16B granule, words on 4B granule.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
    logic [AW-1:0] rel;
    logic          live, match;
    assign rel   = AW'(gi) - head_idx;
    assign live  = ({1'b0, rel} < count);
    assign match = ent_uncache_q[gi]
                 ? (ent_addr_q[gi][31:2] == bus.rd_chk_addr[31:2])
                 : (ent_addr_q[gi][31:4] == bus.rd_chk_addr[31:4]);
    assign hit[gi] = live && match;
  end

  // Issued writes keep no address, so any outstanding write stalls reads.
  assign bus.conflict = (|hit) || (out_cnt_q != '0);
  assign bus.idle     = empty && (out_cnt_q == '0);
  assign bus.err      = bus.wr_done && !fire && (out_cnt_q == '0);

  // The two low address bits never take part in a hazard compare.
  logic unused_rd_bits;
  assign unused_rd_bits = &{1'b0, bus.rd_chk_addr[1:0]};

  // Next-state for pointers and outstanding counter.
  always_comb begin
    head_d    = fire ? head_q + 1'b1 : head_q;
    tail_d    = push ? tail_q + 1'b1 : tail_q;
    out_cnt_d = out_cnt_q;
    case ({fire, bus.wr_done})
      2'b10:   out_cnt_d = out_cnt_q + 1'b1;
      2'b01:   out_cnt_d = (out_cnt_q != '0) ? out_cnt_q - 1'b1 : out_cnt_q;
      default: out_cnt_d = out_cnt_q;
    endcase
  end

  // Control state; reset drops queued and outstanding bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      out_cnt_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  // Entry write at the tail; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_uncache_q[tail_idx] <= bus.wb_uncache;
      ent_addr_q[tail_idx]    <= bus.wb_addr;
      ent_wstrb_q[tail_idx]   <= bus.wb_wstrb;
      ent_data_q[tail_idx]    <= bus.wb_data;
    end
  end
endmodule

// File: tb/tb_cache_wb_buffer.sv
// Testbench for cache_wb_buffer: directed scenarios plus a randomized run
// checked against a queue-based model of the buffer.
module tb_cache_wb_buffer;
  localparam int DEPTH   = 2;
  localparam int MAX_OUT = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cache_wb_buffer_if bus();

  cache_wb_buffer #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic         unc;
    logic [31:0]  addr;
    logic [3:0]   wstrb;
    logic [127:0] data;
  } ent_t;

  ent_t mq[$];   // queued entries, front = oldest
  int   moc;     // writes issued but not acknowledged

  // Advance one clock, updating the reference model from the inputs seen.
  task automatic tick();
    bit   push, fire, rst, done;
    ent_t e;
    push    = bus.wb_valid && (mq.size() < DEPTH);
    fire    = (mq.size() > 0) && (moc < MAX_OUT) && bus.wr_rdy;
    rst     = reset;
    done    = bus.wr_done;
    e.unc   = bus.wb_uncache;
    e.addr  = bus.wb_addr;
    e.wstrb = bus.wb_wstrb;
    e.data  = bus.wb_data;
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete();
      moc = 0;
    end else begin
      if (fire) void'(mq.pop_front());
      if (push) mq.push_back(e);
      if (fire && !done) moc++;
      else if (!fire && done && moc > 0) moc--;
    end
  endtask

  task automatic quiet_inputs();
    bus.wb_valid = 0; bus.wb_uncache = 0; bus.wb_addr = 0; bus.wb_wstrb = 0;
    bus.wb_data = 0; bus.wr_rdy = 0; bus.wr_done = 0; bus.rd_chk_addr = 0;
  endtask

  task automatic drive_push(input logic unc, input logic [31:0] a,
                            input logic [3:0] s, input logic [127:0] d);
    bus.wb_valid = 1; bus.wb_uncache = unc; bus.wb_addr = a;
    bus.wb_wstrb = s; bus.wb_data = d;
  endtask

  task automatic test_reset();
    quiet_inputs();
    reset = 1; tick(); tick(); reset = 0;
    bus.rd_chk_addr = 32'h1C00_1230;
    #1;
    checks++; if (bus.wr_req !== 1'b0) begin failures++; $display("FAIL reset_wr_req got=%0b want=0", bus.wr_req); end
    checks++; if ({bus.wr_type, bus.wr_addr, bus.wr_wstrb, bus.wr_data} !== 167'h0) begin failures++; $display("FAIL reset_wr_fields got type=%0h addr=%h want 0", bus.wr_type, bus.wr_addr); end
    checks++; if (bus.wb_ready !== 1'b1) begin failures++; $display("FAIL reset_wb_ready got=%0b want=1", bus.wb_ready); end
    checks++; if (bus.conflict !== 1'b0) begin failures++; $display("FAIL reset_conflict got=%0b want=0", bus.conflict); end
    checks++; if (bus.idle !== 1'b1) begin failures++; $display("FAIL reset_idle got=%0b want=1", bus.idle); end
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b want=0", bus.err); end
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_line_push();
    logic [127:0] d;
    d = {4{32'hAAAA_AAAA}};
    quiet_inputs();
    drive_push(1'b0, 32'h1C00_1234, 4'h0, d);
    bus.wr_rdy = 1;
    #1;
    checks++; if (bus.wr_req !== 1'b0) begin failures++; $display("FAIL line_latency got=%0b want=0", bus.wr_req); end
    tick();
    bus.wb_valid = 0;
    #1;
    checks++; if (bus.wr_req !== 1'b1) begin failures++; $display("FAIL line_req got=%0b want=1", bus.wr_req); end
    checks++; if (bus.wr_type !== 3'b100) begin failures++; $display("FAIL line_type got=%b want=100", bus.wr_type); end
    checks++; if (bus.wr_addr !== 32'h1C00_1230) begin failures++; $display("FAIL line_addr got=%h want=1c001230", bus.wr_addr); end
    checks++; if (bus.wr_wstrb !== 4'hF) begin failures++; $display("FAIL line_wstrb got=%h want=f", bus.wr_wstrb); end
    checks++; if (bus.wr_data !== d) begin failures++; $display("FAIL line_data got=%h want=%h", bus.wr_data, d); end
    tick();
    #1;
    checks++; if (bus.idle !== 1'b0) begin failures++; $display("FAIL line_idle_out got=%0b want=0", bus.idle); end
    checks++; if (bus.wr_req !== 1'b0) begin failures++; $display("FAIL line_req_after got=%0b want=0", bus.wr_req); end
    bus.wr_done = 1;
    #1;
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL line_done_err got=%0b want=0", bus.err); end
    tick();
    bus.wr_done = 0;
    #1;
    checks++; if (bus.idle !== 1'b1) begin failures++; $display("FAIL line_idle_done got=%0b want=1", bus.idle); end
    $display("test_line_push done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_word_stall();
    logic [127:0] d;
    d = {96'hDEAD_BEEF_0123_4567_89AB_CDEF, 32'h1234_5678};
    quiet_inputs();
    drive_push(1'b1, 32'hBFAF_F004, 4'b0011, d);
    tick();
    bus.wb_valid = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (bus.wr_req !== 1'b1 || bus.wr_type !== 3'b010 || bus.wr_addr !== 32'hBFAF_F004 ||
          bus.wr_wstrb !== 4'b0011 || bus.wr_data !== {96'h0, 32'h1234_5678}) begin
        failures++;
        $display("FAIL word_hold cyc=%0d got req=%0b type=%b addr=%h wstrb=%b data=%h want 1/010/bfaff004/0011/%h",
                 i, bus.wr_req, bus.wr_type, bus.wr_addr, bus.wr_wstrb, bus.wr_data, {96'h0, 32'h1234_5678});
      end
      tick();
    end
    bus.wr_rdy = 1;
    tick();
    bus.wr_rdy = 0;
    #1;
    checks++; if ({bus.wr_req, bus.wr_type, bus.wr_addr, bus.wr_wstrb, bus.wr_data} !== 168'h0) begin failures++; $display("FAIL word_after got req=%0b type=%b addr=%h want all 0", bus.wr_req, bus.wr_type, bus.wr_addr); end
    bus.wr_done = 1; tick(); bus.wr_done = 0;
    $display("test_word_stall done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_full();
    quiet_inputs();
    drive_push(1'b0, 32'h0000_0100, 4'h0, 128'h1); tick();
    #1;
    checks++; if (bus.wb_ready !== 1'b1) begin failures++; $display("FAIL full_ready1 got=%0b want=1", bus.wb_ready); end
    drive_push(1'b0, 32'h0000_0200, 4'h0, 128'h2); tick();
    #1;
    checks++; if (bus.wb_ready !== 1'b0) begin failures++; $display("FAIL full_ready2 got=%0b want=0", bus.wb_ready); end
    drive_push(1'b0, 32'h0000_0300, 4'h0, 128'h3); tick();
    bus.wb_valid = 0; bus.wr_rdy = 1;
    #1;
    checks++; if (bus.wr_addr !== 32'h0000_0100) begin failures++; $display("FAIL full_order0 got=%h want=00000100", bus.wr_addr); end
    tick();
    #1;
    checks++; if (bus.wr_addr !== 32'h0000_0200) begin failures++; $display("FAIL full_order1 got=%h want=00000200", bus.wr_addr); end
    tick();
    bus.wr_rdy = 0; bus.wr_done = 1; tick(); tick(); bus.wr_done = 0;
    #1;
    checks++; if (bus.idle !== 1'b1) begin failures++; $display("FAIL full_third_dropped idle got=%0b want=1", bus.idle); end
    $display("test_full done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_out_limit();
    quiet_inputs();
    drive_push(1'b0, 32'h0000_A000, 4'h0, 128'hA); tick();
    drive_push(1'b0, 32'h0000_B000, 4'h0, 128'hB); tick();
    drive_push(1'b0, 32'h0000_C000, 4'h0, 128'hC);
    bus.wr_rdy = 1;
    tick();         // A fires, queue full so C waits
    tick();         // B fires, C pushed
    bus.wb_valid = 0;
    #1;
    checks++; if (bus.wr_req !== 1'b0) begin failures++; $display("FAIL limit_block got=%0b want=0", bus.wr_req); end
    bus.wr_done = 1;
    #1;
    checks++; if (bus.wr_req !== 1'b0) begin failures++; $display("FAIL limit_block_done got=%0b want=0", bus.wr_req); end
    tick();         // one ack frees a slot
    #1;
    checks++; if (bus.wr_req !== 1'b1 || bus.wr_addr !== 32'h0000_C000) begin failures++; $display("FAIL limit_third got req=%0b addr=%h want 1/0000c000", bus.wr_req, bus.wr_addr); end
    tick();         // C fires together with an ack: count stays 1
    bus.wr_done = 0;
    #1;
    checks++; if (bus.idle !== 1'b0 || bus.conflict !== 1'b1) begin failures++; $display("FAIL limit_cnt1 got idle=%0b conflict=%0b want 0/1", bus.idle, bus.conflict); end
    bus.wr_done = 1; tick(); bus.wr_done = 0;
    #1;
    checks++; if (bus.idle !== 1'b1) begin failures++; $display("FAIL limit_drained got=%0b want=1", bus.idle); end
    $display("test_out_limit done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_conflict();
    quiet_inputs();
    drive_push(1'b0, 32'h0000_1000, 4'h0, 128'h5); tick();
    drive_push(1'b1, 32'h0000_2004, 4'h1, 128'h6); tick();
    bus.wb_valid = 0;
    bus.rd_chk_addr = 32'h0000_100C; #1;
    checks++; if (bus.conflict !== 1'b1) begin failures++; $display("FAIL conf_line_hit got=%0b want=1", bus.conflict); end
    bus.rd_chk_addr = 32'h0000_1010; #1;
    checks++; if (bus.conflict !== 1'b0) begin failures++; $display("FAIL conf_line_miss got=%0b want=0", bus.conflict); end
    bus.rd_chk_addr = 32'h0000_2006; #1;
    checks++; if (bus.conflict !== 1'b1) begin failures++; $display("FAIL conf_word_hit got=%0b want=1", bus.conflict); end
    bus.rd_chk_addr = 32'h0000_2008; #1;
    checks++; if (bus.conflict !== 1'b0) begin failures++; $display("FAIL conf_word_miss got=%0b want=0", bus.conflict); end
    bus.wr_rdy = 1; tick(); tick(); bus.wr_rdy = 0;
    bus.rd_chk_addr = 32'h0000_3000; #1;
    checks++; if (bus.conflict !== 1'b1) begin failures++; $display("FAIL conf_outstanding got=%0b want=1", bus.conflict); end
    bus.wr_done = 1; tick(); tick(); bus.wr_done = 0;
    #1;
    checks++; if (bus.conflict !== 1'b0) begin failures++; $display("FAIL conf_cleared got=%0b want=0", bus.conflict); end
    $display("test_conflict done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_err_reset();
    quiet_inputs();
    bus.wr_done = 1; #1;
    checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL err_pulse got=%0b want=1", bus.err); end
    tick();
    bus.wr_done = 0; #1;
    checks++; if (bus.err !== 1'b0 || bus.idle !== 1'b1) begin failures++; $display("FAIL err_after got err=%0b idle=%0b want 0/1", bus.err, bus.idle); end
    drive_push(1'b0, 32'h0000_5000, 4'h0, 128'h7); tick();
    drive_push(1'b0, 32'h0000_6000, 4'h0, 128'h8); tick();
    bus.wb_valid = 0; bus.wr_rdy = 1; tick(); bus.wr_rdy = 0;
    drive_push(1'b0, 32'h0000_7000, 4'h0, 128'h9); tick();
    bus.wb_valid = 0;
    reset = 1; tick(); reset = 0;
    bus.rd_chk_addr = 32'h0000_6000; bus.wr_rdy = 1; #1;
    checks++; if (bus.idle !== 1'b1 || bus.wb_ready !== 1'b1 || bus.wr_req !== 1'b0 || bus.conflict !== 1'b0) begin
      failures++; $display("FAIL reset_mid got idle=%0b ready=%0b req=%0b conflict=%0b want 1/1/0/0", bus.idle, bus.wb_ready, bus.wr_req, bus.conflict);
    end
    tick(); tick(); #1;
    checks++; if (bus.wr_req !== 1'b0) begin failures++; $display("FAIL reset_no_req got=%0b want=0", bus.wr_req); end
    bus.wr_rdy = 0;
    $display("test_err_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_random();
    bit           e_req, e_ready, e_conf, e_idle, e_err;
    logic [2:0]   e_type;
    logic [31:0]  e_addr;
    logic [3:0]   e_wstrb;
    logic [127:0] e_data;
    quiet_inputs();
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.wb_valid    = ($urandom % 3) != 0;
      bus.wb_uncache  = $urandom % 2;
      bus.wb_addr     = 32'h0000_1000 + $urandom_range(0, 63);
      bus.wb_wstrb    = $urandom % 16;
      bus.wb_data     = {$urandom, $urandom, $urandom, $urandom};
      bus.wr_rdy      = ($urandom % 4) != 0;
      bus.wr_done     = (moc > 0) ? ($urandom % 2) : (($urandom % 16) == 0);
      bus.rd_chk_addr = 32'h0000_1000 + $urandom_range(0, 63);
      reset           = ($urandom % 100) == 0;
      #1;
      e_ready = mq.size() < DEPTH;
      e_req   = (mq.size() > 0) && (moc < MAX_OUT);
      e_idle  = (mq.size() == 0) && (moc == 0);
      e_err   = bus.wr_done && !(e_req && bus.wr_rdy) && (moc == 0);
      e_conf  = (moc != 0);
      foreach (mq[k]) begin
        if (mq[k].unc ? (mq[k].addr[31:2] == bus.rd_chk_addr[31:2])
                      : (mq[k].addr[31:4] == bus.rd_chk_addr[31:4])) e_conf = 1;
      end
      e_type = 0; e_addr = 0; e_wstrb = 0; e_data = 0;
      if (e_req) begin
        if (mq[0].unc) begin
          e_type = 3'b010; e_addr = mq[0].addr; e_wstrb = mq[0].wstrb; e_data = {96'h0, mq[0].data[31:0]};
        end else begin
          e_type = 3'b100; e_addr = {mq[0].addr[31:4], 4'h0}; e_wstrb = 4'hF; e_data = mq[0].data;
        end
      end
      checks++;
      if (bus.wb_ready !== e_ready || bus.wr_req !== e_req || bus.idle !== e_idle ||
          bus.err !== e_err || bus.conflict !== e_conf) begin
        failures++;
        $display("FAIL rand_status cyc=%0d got ready=%0b req=%0b idle=%0b err=%0b conf=%0b want %0b/%0b/%0b/%0b/%0b",
                 cyc, bus.wb_ready, bus.wr_req, bus.idle, bus.err, bus.conflict, e_ready, e_req, e_idle, e_err, e_conf);
      end
      checks++;
      if (bus.wr_type !== e_type || bus.wr_addr !== e_addr || bus.wr_wstrb !== e_wstrb || bus.wr_data !== e_data) begin
        failures++;
        $display("FAIL rand_req cyc=%0d got type=%b addr=%h wstrb=%h data=%h want %b/%h/%h/%h",
                 cyc, bus.wr_type, bus.wr_addr, bus.wr_wstrb, bus.wr_data, e_type, e_addr, e_wstrb, e_data);
      end
      tick();
    end
    reset = 0;
    quiet_inputs();
    $display("test_random done checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    moc = 0;
    reset = 1;
    quiet_inputs();
    test_reset();
    test_line_push();
    test_word_stall();
    test_full();
    test_out_limit();
    test_conflict();
    test_err_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cache_wb_buffer.md
Name: cache_wb_buffer

Overview:
- Write-side counterpart of the cache miss-read path.
- Accepts dirty victim lines and uncached stores from the cache, queues them, and issues them to the AXI bridge over the cache write interface (wr_req/wr_rdy).
- Tracks writes that have been issued but not yet acknowledged.
- Flags read-after-write address conflicts so the cache miss-read path stalls until the data is safely ordered.

Parameters:
DEPTH, 2, queue entries (power of two, >=2)
MAX_OUT, 2, max issued-but-unacknowledged writes (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
wb_valid  in  1  cache pushes an entry this cycle
wb_ready  out  1  queue can accept (= !full)
wb_uncache  in  1  1: single-word uncached store; 0: 128-bit line writeback
wb_addr  in  32  byte address
wb_wstrb  in  4  byte enables (used only when wb_uncache=1)
wb_data  in  128  line data; word data in [31:0]
wr_req  out  1  write request to bridge
wr_type  out  3  3'b100 line, 3'b010 word
wr_addr  out  32  request address
wr_wstrb  out  4  request byte enables
wr_data  out  128  request data
wr_rdy  in  1  bridge accepts the request
wr_done  in  1  one pulse per completed write (bvalid)
rd_chk_addr  in  32  address of the pending miss/uncached read
conflict  out  1  read must stall
idle  out  1  queue empty and nothing outstanding
err  out  1  one-cycle pulse: wr_done received with no outstanding write

Behaviour:
- Storage and pointers:
  - Circular FIFO of DEPTH entries {uncache, addr, wstrb, data}.
  - Head/tail pointers have log2(DEPTH) bits plus a wrap bit.
  - full = pointers equal except the wrap bit; empty = pointers fully equal.
- Push: push = wb_valid && wb_ready. The entry is written at the tail on the rising edge and the tail increments. wb_valid while full is ignored; the cache must hold it.
- Issue:
  - wr_req = !empty && (out_cnt < MAX_OUT). It is driven combinationally from registered state and never depends on wr_rdy.
  - fire = wr_req && wr_rdy. On fire the head increments and the entry is released, because the bridge has latched the data.
  - While wr_req=1 and wr_rdy=0, all wr_* outputs hold stable.
- Request encoding:
  - Line entry: wr_type=3'b100, wr_addr={addr[31:4],4'b0}, wr_wstrb=4'hF, wr_data=data.
  - Word entry: wr_type=3'b010, wr_addr=addr, wr_wstrb=wstrb, wr_data={96'b0,data[31:0]}.
  - When wr_req=0, all wr_* outputs are 0.
- Outstanding counter out_cnt (width clog2(MAX_OUT+1)):
  - fire without wr_done: +1.
  - wr_done without fire: -1.
  - fire and wr_done together: unchanged.
  - wr_done with out_cnt==0 and no fire: counter stays 0, err=1 for that cycle.
- Ordering:
  - Entries issue in strict FIFO order.
  - A push and a fire in the same cycle are both honoured; the count is unchanged.
  - A push into an empty queue becomes visible on wr_req the next cycle (1-cycle latency minimum).
- Conflict (combinational):
  - conflict = 1 if any valid queued entry matches rd_chk_addr, or out_cnt != 0.
  - A line entry matches on addr[31:4]. A word entry matches on addr[31:2].
  - The outstanding clause is deliberately conservative, because addresses of issued writes are not retained.
- idle = empty && out_cnt==0. Used by cacop/ibar drain.
- Reset:
  - Pointers and out_cnt are cleared; entry contents need not be cleared.
  - Values the cycle after reset: wr_req=0, wr_type/addr/wstrb/data=0, wb_ready=1, conflict=0, idle=1, err=0.
  - Reset mid-transaction discards queued and outstanding state. No further wr_req is issued until a new push.
- Pointer wrap-around is handled by the wrap bit; there is no special case at index DEPTH-1.

Test Plan:
1. Line push, bridge ready: push addr 0x1C00_1234, data 128'hA..A, wr_rdy=1 -> next cycle wr_req=1, wr_type=100, wr_addr=0x1C00_1230, wr_wstrb=F. Fire that cycle; out_cnt=1, idle=0. wr_done pulse -> out_cnt=0, idle=1.
2. Uncached word with stalled bridge: push uncache addr 0xBFAF_F004, wstrb=4'b0011, data[31:0]=0x1234_5678, wr_rdy=0 for 5 cycles -> wr_* held stable at type 010, addr 0xBFAF_F004, wstrb 0011, data 0x...1234_5678 until wr_rdy=1; then wr_req=0.
3. Full and back-pressure: push 3 entries with wr_rdy=0 (DEPTH=2) -> wb_ready=0 after the 2nd push and the 3rd is not accepted. Raise wr_rdy -> entries issue in push order. Cycling pushes/fires through several wraps keeps FIFO order.
4. Outstanding limit: MAX_OUT=2, 3 queued, wr_rdy=1, no wr_done -> two fires, then wr_req=0. One wr_done -> third fires the next cycle. wr_done in the same cycle as a fire -> out_cnt unchanged.
5. Conflict: queue line 0x0000_1000 with wr_rdy=0; rd_chk_addr=0x0000_100C -> conflict=1; rd_chk_addr=0x0000_1010 -> conflict=0. After the fire, conflict=1 until wr_done.
6. Error and reset: wr_done with out_cnt=0 -> err=1 for one cycle, out_cnt stays 0. Assert reset with 2 queued and 1 outstanding -> next cycle idle=1, wb_ready=1, wr_req=0, conflict=0.
